uart_packet_parser: RTL and testbench

//  Downstream consumer of the UART receive FIFO. Pops bytes and hunts for a frame: SOF, LEN, LEN payload bytes, CHK.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_pkt_buf.sv | 39 +++
 rtl/uart_packet_parser.sv | 195 +++++++++++++++++++
 tb/tb_uart_packet_parser.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART framing constants and frame-parser state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [7:0] C_SOF_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkt_buf
// Description : DEPTH x 8 payload register file, one write port, one
//               registered read port (read data register is reset).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_packet_parser
// Description : Pops RX FIFO bytes, parses SOF/LEN/payload/CHK frames and
//               releases checksum-verified payloads on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_packet_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = C_SOF_BYTE,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       err_len,
    output logic       err_chk,
    output logic       err_timeout
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [8:0]    C_MAX_LEN9 = 9'(MAX_LEN);
    localparam logic [GW-1:0] C_GAP_MAX  = GW'(TIMEOUT_CYCLES - 1);

    frame_state_t  r_state;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic [LW-1:0] r_rd_idx;
    logic [7:0]    r_chk;
    logic [GW-1:0] r_gap;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_frame_ok;
    logic          r_err_len;
    logic          r_err_chk;
    logic          r_err_timeout;

    logic          w_in_frame;
    logic          w_timeout;
    logic          w_len_bad;
    logic [LW-1:0] w_idx_nxt;
    logic [LW-1:0] w_rd_nxt;
    logic          w_buf_wr_en;
    logic          w_buf_rd_en;
    logic [AW-1:0] w_buf_rd_addr;
    logic [7:0]    w_buf_rd_data;

    // Reset gating keeps the FIFO untouched while the parser is held in reset.
    assign fifo_rd    = !reset && !fifo_empty && (r_state != ST_DRAIN);
    assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
    assign w_timeout  = w_in_frame && !fifo_rd && (r_gap == C_GAP_MAX);
    assign w_len_bad  = (fifo_data == 8'h00) || ({1'b0, fifo_data} > C_MAX_LEN9);
    assign w_idx_nxt  = r_idx + LW'(1);
    assign w_rd_nxt   = r_rd_idx + LW'(1);
    assign w_buf_wr_en = fifo_rd && (r_state == ST_PAYLOAD);

    // Read address runs one entry ahead so out_data is ready with out_valid.
    always_comb begin
        w_buf_rd_en   = 1'b0;
        w_buf_rd_addr = '0;
        if ((r_state == ST_CHK) && fifo_rd && (fifo_data == r_chk)) begin
            w_buf_rd_en = 1'b1;
        end else if ((r_state == ST_DRAIN) && r_out_valid && out_ready && !r_out_last) begin
            w_buf_rd_en   = 1'b1;
            w_buf_rd_addr = w_rd_nxt[AW-1:0];
        end
    end

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (w_buf_wr_en),
        .wr_addr (r_idx[AW-1:0]),
        .wr_data (fifo_data),
        .rd_en   (w_buf_rd_en),
        .rd_addr (w_buf_rd_addr),
        .rd_data (w_buf_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_idx         <= '0;
            r_rd_idx      <= '0;
            r_chk         <= 8'h00;
            r_gap         <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_frame_ok    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_timeout <= 1'b0;

            if (w_in_frame && !fifo_rd && (r_gap != C_GAP_MAX)) begin
                r_gap <= r_gap + GW'(1);
            end else begin
                r_gap <= '0;
            end

            if (w_timeout) begin
                r_err_timeout <= 1'b1;
                r_state       <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (fifo_rd && (fifo_data == SOF_BYTE)) begin
                            r_state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (fifo_rd) begin
                            if (w_len_bad) begin
                                r_err_len <= 1'b1;
                                r_state   <= ST_IDLE;
                            end else begin
                                r_len   <= fifo_data[LW-1:0];
                                r_chk   <= fifo_data;
                                r_idx   <= '0;
                                r_state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (fifo_rd) begin
                            r_chk <= r_chk ^ fifo_data;
                            r_idx <= w_idx_nxt;
                            if (w_idx_nxt == r_len) begin
                                r_state <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (fifo_rd) begin
                            if (fifo_data == r_chk) begin
                                r_frame_ok  <= 1'b1;
                                r_rd_idx    <= '0;
                                r_out_valid <= 1'b1;
                                r_out_last  <= (r_len == LW'(1));
                                r_state     <= ST_DRAIN;
                            end else begin
                                r_err_chk <= 1'b1;
                                r_state   <= ST_IDLE;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (r_out_valid && out_ready) begin
                            if (r_out_last) begin
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_rd_idx   <= w_rd_nxt;
                                r_out_last <= (w_rd_nxt == (r_len - LW'(1)));
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_data    = w_buf_rd_data;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign frame_ok    = r_frame_ok;
    assign err_len     = r_err_len;
    assign err_chk     = r_err_chk;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_packet_parser
// Description : Scoreboard bench for uart_packet_parser with a queue-based
//               RX FIFO model and a decoupled output/event monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_packet_parser;

    localparam int C_MAX_LEN = 16;
    localparam int C_TIMEOUT = 20;

    localparam int EV_OK  = 0;
    localparam int EV_LEN = 1;
    localparam int EV_CHK = 2;
    localparam int EV_TO  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       frame_ok;
    logic       err_len;
    logic       err_chk;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [8:0] exp_beat[$];
    int         exp_ev[$];
    int         beats_seen = 0;
    int         ready_mode = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    int         npulse;
    int         code;
    int         ev;
    logic [8:0] beat;

    uart_packet_parser #(
        .SOF_BYTE       (8'hA5),
        .MAX_LEN        (C_MAX_LEN),
        .TIMEOUT_CYCLES (C_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd     (fifo_rd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .frame_ok    (frame_ok),
        .err_len     (err_len),
        .err_chk     (err_chk),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RX FIFO model: head byte consumed on the edge where fifo_rd is high.
    always @(posedge clk) begin
        if (fifo_rd && (fifo_q.size() > 0)) begin
            void'(fifo_q.pop_front());
        end
        #1;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid) begin
                check("drain_no_rd", 32'(fifo_rd), 32'd0);
            end
            if (fifo_rd) begin
                check("rd_nonempty", 32'(fifo_empty), 32'd0);
            end
            if (out_valid && out_ready) begin
                beats_seen++;
                if (exp_beat.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got data %0h last %0b expected none", out_data, out_last);
                end else begin
                    beat = exp_beat.pop_front();
                    check("beat_data", 32'(out_data), 32'(beat[7:0]));
                    check("beat_last", 32'(out_last), 32'(beat[8]));
                end
            end
            npulse = int'(frame_ok) + int'(err_len) + int'(err_chk) + int'(err_timeout);
            if (npulse != 0) begin
                check("pulse_excl", 32'(npulse), 32'd1);
                code = frame_ok ? EV_OK : err_len ? EV_LEN : err_chk ? EV_CHK : EV_TO;
                if (exp_ev.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL event_unexpected: got code %0d expected none", code);
                end else begin
                    ev = exp_ev.pop_front();
                    check("event_code", 32'(code), 32'(ev));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic send(input logic [7:0] b[$]);
        foreach (b[k]) fifo_q.push_back(b[k]);
    endtask

    task automatic expect_beats(input logic [7:0] d[$]);
        foreach (d[k]) exp_beat.push_back({(k == d.size() - 1), d[k]});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (((fifo_q.size() != 0) || (exp_ev.size() != 0) || (exp_beat.size() != 0)) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_done: got %0d pending events, %0d pending beats expected 0", name, exp_ev.size(), exp_beat.size());
            exp_ev.delete();
            exp_beat.delete();
            fifo_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_last"}, 32'(out_last), 32'd0);
        check({name, "_out_data"}, 32'(out_data), 32'd0);
        check({name, "_fifo_rd"}, 32'(fifo_rd), 32'd0);
        check({name, "_pulses"}, 32'({frame_ok, err_len, err_chk, err_timeout}), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #2 reset = 1'b0;

        // Basic three-byte frame
        exp_ev.push_back(EV_OK);
        expect_beats('{8'h11, 8'h22, 8'h33});
        send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        wait_idle("t1", 100);

        // Leading noise, single-byte payload
        exp_ev.push_back(EV_OK);
        expect_beats('{8'h7E});
        send('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F});
        wait_idle("t2", 100);

        // Bad checksum, then the same frame with a good checksum
        exp_ev.push_back(EV_CHK);
        exp_ev.push_back(EV_OK);
        expect_beats('{8'h11, 8'h22, 8'h33});
        send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
        send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        wait_idle("t3", 100);

        // LEN out of range on both sides, then a MAX_LEN frame
        exp_ev.push_back(EV_LEN);
        exp_ev.push_back(EV_LEN);
        send('{8'hA5, 8'h00, 8'hA5, 8'h11});
        wait_idle("t4", 100);
        exp_ev.push_back(EV_OK);
        expect_beats('{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                       8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F});
        send('{8'hA5, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
               8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10});
        wait_idle("t4max", 200);

        // SOF value inside payload is plain data
        exp_ev.push_back(EV_OK);
        expect_beats('{8'hA5, 8'hA5});
        send('{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02});
        wait_idle("tsof", 100);

        // Inter-byte timeout, then a good frame
        exp_ev.push_back(EV_TO);
        send('{8'hA5, 8'h02, 8'h10});
        wait_idle("t5", 4 * C_TIMEOUT);
        exp_ev.push_back(EV_OK);
        expect_beats('{8'h11, 8'h22, 8'h33});
        send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        wait_idle("t5b", 100);

        // Back-pressure with a byte waiting in the FIFO, then reset mid-drain
        ready_mode = 1;
        n = 0;
        beats_seen = 0;
        exp_ev.push_back(EV_OK);
        expect_beats('{8'h01, 8'h02, 8'h03, 8'h04});
        send('{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h55});
        while ((beats_seen < 2) && (n < 200)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t6_two_beats", 32'(beats_seen >= 2), 32'd1);
        ready_mode = 2;
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t6_rst");
        check("t6_fifo_kept", 32'(fifo_q.size()), 32'd1);
        exp_beat.delete();
        @(posedge clk);
        #2 reset = 1'b0;
        ready_mode = 0;
        wait_idle("t6", 100);

        check("end_events", 32'(exp_ev.size()), 32'd0);
        check("end_beats", 32'(exp_beat.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
